// File: rtl/rr_arb4_sched_pkg.sv
// rr_arb4_sched_pkg: shared FSM encoding, requester count and grant decoding for the 4-way scheduler
package rr_arb4_sched_pkg;
    localparam int NREQ = 4;

    typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    function automatic logic [1:0] onehot2idx(input logic [NREQ-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction
endpackage

// File: rtl/rr_arb4_sched_if.sv
// rr_arb4_sched_if: request/grant bundle between the requesters and the scheduler
interface rr_arb4_sched_if;
    import rr_arb4_sched_pkg::*;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0] gnt_id;
    logic gnt_vld;
    logic tout;
    modport master (output req, input gnt, gnt_id, gnt_vld, tout);
    modport slave (input req, output gnt, gnt_id, gnt_vld, tout);
endinterface

// File: rtl/rr_arb4_sched_pick4.sv
// rr_pick4: combinational round-robin pick, first masked request at or after ptr (mod 4)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic [3:0] pick,
    output logic       any
);
    logic [3:0] m, rot, first;

    always_comb begin
        m = req & mask;
        rot = '0;
        pick = '0;
        for (int i = 0; i < 4; i++) rot[i] = m[ptr + 2'(i)];
        first = rot & (~rot + 4'd1);
        for (int i = 0; i < 4; i++) pick[ptr + 2'(i)] = first[i];
        any = |m;
    end
endmodule

// File: rtl/rr_arb4_sched.sv
// rr_arb4_sched: round-robin owner scheduler with registered one-hot grant
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles and pulse tout.
module rr_arb4_sched
    import rr_arb4_sched_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input logic            clk,
    input logic            reset,
    rr_arb4_sched_if.slave bus
);
    state_t state, state_nx;
    logic [1:0] ptr, ptr_nx, owner;
    logic [NREQ-1:0] gnt, gnt_nx, pick;
    logic any, keep, leave, expire;

    if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("rr_arb4_sched: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
    end

    // Searching from ptr_nx lets a release hand over at the same edge it frees the resource.
    rr_pick4 u_pick (.req(bus.req), .ptr(ptr_nx), .mask(4'b1111), .pick(pick), .any(any));

    assign owner = onehot2idx(gnt);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic tout;

    assign expire = state == ST_OWN && (bus.req & gnt) != '0 && hold_cnt == CNT_W'(MAX_HOLD - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            tout <= 1'b0;
        end else begin
            hold_cnt <= !keep ? '0 : hold_cnt == CNT_W'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
            tout <= expire;
        end
    end

    assign bus.tout = tout;
`else
    assign expire = 1'b0;
    assign bus.tout = 1'b0;
`endif

    always_comb begin
        keep = state == ST_OWN && (bus.req & gnt) != '0 && !expire;
        leave = state == ST_OWN && !keep;
        ptr_nx = leave ? owner + 2'd1 : ptr;
        gnt_nx = keep ? gnt : pick;
        state_nx = (keep || any) ? ST_OWN : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr <= '0;
            gnt <= '0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            gnt <= gnt_nx;
        end
    end

    assign bus.gnt = gnt;
    assign bus.gnt_id = owner;
    assign bus.gnt_vld = |gnt;
endmodule

// File: tb/tb_rr_arb4_sched.sv
// tb_rr_arb4_sched: directed and randomised checks of rr_arb4_sched
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined; otherwise indefinite hold is checked.
module tb_rr_arb4_sched;
    logic clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_pass = 0;

    rr_arb4_sched_if bus ();
    rr_arb4_sched dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp, rq, g;
        logic [1:0] eid;
        int wait_c [4];
        int held [4];
        int len [4];
        int worst;
        reset = 1'b1;
        bus.req = 4'b0000;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_vld", 32'(bus.gnt_vld), 0);
        chk("rst_id", 32'(bus.gnt_id), 0);
        chk("rst_tout", 32'(bus.tout), 0);

        reset = 1'b0;
        bus.req = 4'b1010;
        step();
        chk("first_gnt", 32'(bus.gnt), 32'b0010);
        chk("first_id", 32'(bus.gnt_id), 1);
        chk("first_vld", 32'(bus.gnt_vld), 1);
        bus.req = 4'b1000;
        step();
        chk("handover_gnt", 32'(bus.gnt), 32'b1000);
        chk("handover_id", 32'(bus.gnt_id), 3);
        bus.req = 4'b0000;
        step();
        chk("idle_gnt", 32'(bus.gnt), 0);
        chk("idle_vld", 32'(bus.gnt_vld), 0);

        // ptr wrapped 3 -> 0, so the rotation starts at requester 0
        bus.req = 4'hf;
        step();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("rr_k%0d_c%0d", k, c), 32'(bus.gnt), 32'(exp));
                bus.req = (c == 2) ? (4'hf & ~exp) : 4'hf;
                step();
                bus.req = 4'hf;
            end
        end
        chk("rr_after", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b0000;
        step();
        chk("rr_idle", 32'(bus.gnt), 0);

`ifdef ARB_TIMEOUT_EN
        bus.req = 4'b0001;
        step();
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("to1_gnt_%0d", c), 32'(bus.gnt), 32'b0001);
            chk($sformatf("to1_tout_%0d", c), 32'(bus.tout), 0);
            step();
        end
        chk("to1_regrant", 32'(bus.gnt), 32'b0001);
        chk("to1_pulse", 32'(bus.tout), 1);
        step();
        chk("to1_pulse_end", 32'(bus.tout), 0);
        chk("to1_hold", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b1000;
        step();
        bus.req = 4'b0000;
        step();
        bus.req = 4'b0011;
        step();
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("to2_gnt_%0d", c), 32'(bus.gnt), 32'b0001);
            step();
        end
        chk("to2_handover", 32'(bus.gnt), 32'b0010);
        chk("to2_pulse", 32'(bus.tout), 1);
        bus.req = 4'b0000;
        step();
`else
        bus.req = 4'b0001;
        step();
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("hold_gnt_%0d", c), 32'(bus.gnt), 32'b0001);
            chk($sformatf("hold_tout_%0d", c), 32'(bus.tout), 0);
            step();
        end
        bus.req = 4'b0000;
        step();
`endif

        // leave ptr at 2 before the mid-grant reset so a missed ptr reset shows up
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0100;
        step();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'b0100);
        reset = 1'b1;
        step();
        chk("mid_rst_gnt", 32'(bus.gnt), 0);
        chk("mid_rst_vld", 32'(bus.gnt_vld), 0);
        reset = 1'b0;
        bus.req = 4'hf;
        step();
        chk("post_rst_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b0000;
        step();

        for (int i = 0; i < 4; i++) begin
            wait_c[i] = 0;
            held[i] = 0;
            len[i] = 1;
        end
        for (int t = 0; t < 3000; t++) begin
            rq = bus.req;
            step();
            g = bus.gnt;
            eid = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
            chk("rnd_onehot", 32'($onehot0(g)), 1);
            chk("rnd_only_req", 32'(g & ~rq), 0);
            chk("rnd_id_vld", {29'd0, bus.gnt_vld, bus.gnt_id}, {29'd0, |g, eid});
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                wait_c[i] = (rq[i] && !g[i]) ? wait_c[i] + 1 : 0;
                if (wait_c[i] > worst) worst = wait_c[i];
            end
            chk("rnd_starve", 32'(worst > 3 * 16 + 3), 0);
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    held[i]++;
                    if (held[i] >= len[i]) begin
                        bus.req[i] = 1'b0;
                        held[i] = 0;
                    end
                end else if (!bus.req[i] && ($urandom % 2) == 1) begin
                    bus.req[i] = 1'b1;
                    len[i] = $urandom_range(1, 5);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
